// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter giving two requesters one-at-a-time access to a shared combinational ALU.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [5:0]         req_funct3,
    input  logic [13:0]        req_funct7,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_ctrl,
    input  logic [WIDTH-1:0]   alu_result,
    output logic [1:0]         resp_valid,
    input  logic [1:0]         resp_ready,
    output logic [WIDTH-1:0]   resp_data,
    output logic               resp_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, state_nxt;
    logic ptr, gnt, sel, sel_ok;
    logic [3:0] sel_code;
    logic [2:0] ctrl, sel_ctrl;
    logic [WIDTH-1:0] op_a, op_b;
    logic unused_f7;
    assign unused_f7 = ^{req_funct7[13], req_funct7[11:6], req_funct7[4:0]};
    always_comb begin
        sel = (req_valid == 2'b11) ? ptr : req_valid[1];
        sel_code = sel ? {req_funct7[12], req_funct3[5:3]} : {req_funct7[5], req_funct3[2:0]};
        sel_ok = 1'b1;
        sel_ctrl = 3'b000;
        case (sel_code)
            4'b0000: sel_ctrl = 3'b001;
            4'b1000: sel_ctrl = 3'b000;
            4'b0111: sel_ctrl = 3'b010;
            4'b0110: sel_ctrl = 3'b011;
            4'b0001: sel_ctrl = 3'b100;
            4'b0010: sel_ctrl = 3'b110;
            default: sel_ok = 1'b0;
        endcase
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = |req_valid ? (sel_ok ? ISSUE : RESP) : IDLE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = resp_ready[gnt] ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end
    // rst_n gating keeps the accept strobe low while reset is held
    assign req_ready  = (state == IDLE && rst_n && |req_valid) ? (2'b01 << sel) : 2'b00;
    assign resp_valid = (state == RESP) ? (2'b01 << gnt) : 2'b00;
    assign alu_a      = (state == ISSUE) ? op_a : '0;
    assign alu_b      = (state == ISSUE) ? op_b : '0;
    assign alu_ctrl   = (state == ISSUE) ? ctrl : 3'b000;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            gnt       <= 1'b0;
            ctrl      <= 3'b000;
            op_a      <= '0;
            op_b      <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (|req_valid) begin
                    gnt       <= sel;
                    ctrl      <= sel_ctrl;
                    op_a      <= sel ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                    op_b      <= sel ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                    resp_data <= '0;
                    resp_err  <= !sel_ok;
                end
                ISSUE: resp_data <= alu_result;
                RESP: if (resp_ready[gnt]) ptr <= !gnt;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench; acceptances push expected responses, a negedge monitor pops and compares.
module tb_alu_arbiter;
    localparam int W = 32;
    logic clk = 0, rst_n = 0;
    logic [1:0] req_valid = 0, req_ready, resp_valid, resp_ready = 0;
    logic [5:0] req_funct3 = 0;
    logic [13:0] req_funct7 = 0;
    logic [2*W-1:0] req_a = 0, req_b = 0;
    logic [W-1:0] alu_a, alu_b, alu_result, resp_data;
    logic [2:0] alu_ctrl;
    logic resp_err;

    typedef struct {
        bit who;
        bit legal;
        logic [2:0] ctrl;
        logic [W-1:0] a, b, res;
        int acc;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0, errors = 0, cyc = 0;
    bit pref = 0, iss, due, w;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_funct7(req_funct7), .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // shared ALU environment
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_a - alu_b;
            3'b001:  alu_result = alu_a + alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a << alu_b[4:0];
            3'b110:  alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input bit who, input logic [3:0] code, input logic [W-1:0] a, b, input int acc);
        exp_t r;
        r.who = who; r.a = a; r.b = b; r.acc = acc; r.legal = 1; r.ctrl = 0; r.res = 0;
        case (code)
            4'b0000: begin r.ctrl = 3'b001; r.res = a + b; end
            4'b1000: begin r.ctrl = 3'b000; r.res = a - b; end
            4'b0111: begin r.ctrl = 3'b010; r.res = a & b; end
            4'b0110: begin r.ctrl = 3'b011; r.res = a | b; end
            4'b0001: begin r.ctrl = 3'b100; r.res = a << b[4:0]; end
            4'b0010: begin r.ctrl = 3'b110; r.res = ($signed(a) < $signed(b)) ? 1 : 0; end
            default: r.legal = 0;
        endcase
        return r;
    endfunction

    always @(negedge clk) if (rst_n) begin
        cyc++;
        if (q.size() != 0) begin
            e = q[0];
            iss = e.legal && cyc == e.acc + 1;
            due = cyc >= e.acc + (e.legal ? 2 : 1);
            chk("req_ready_busy", req_ready, 0);
            chk("alu_ctrl", alu_ctrl, iss ? e.ctrl : 3'b000);
            chk("alu_a", alu_a, iss ? e.a : '0);
            chk("alu_b", alu_b, iss ? e.b : '0);
            chk("resp_valid", resp_valid, due ? (e.who ? 2'b10 : 2'b01) : 2'b00);
            if (due) begin
                chk("resp_data", resp_data, e.legal ? e.res : '0);
                chk("resp_err", resp_err, !e.legal);
                if (resp_ready[e.who]) begin
                    void'(q.pop_front());
                    pref = !e.who;
                end
            end
        end else begin
            w = (req_valid == 2'b11) ? pref : req_valid[1];
            chk("req_ready", req_ready, req_valid == 0 ? 2'b00 : (w ? 2'b10 : 2'b01));
            chk("resp_valid_idle", resp_valid, 0);
            chk("alu_ctrl_idle", alu_ctrl, 0);
            if (req_valid != 0)
                q.push_back(model(w, w ? {req_funct7[12], req_funct3[5:3]} : {req_funct7[5], req_funct3[2:0]},
                                  w ? req_a[2*W-1:W] : req_a[W-1:0], w ? req_b[2*W-1:W] : req_b[W-1:0], cyc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [2:0] f3, input logic [6:0] f7, input logic [W-1:0] a, b);
        if (i == 0) begin
            req_funct3[2:0] = f3; req_funct7[6:0] = f7; req_a[W-1:0] = a; req_b[W-1:0] = b;
        end else begin
            req_funct3[5:3] = f3; req_funct7[13:7] = f7; req_a[2*W-1:W] = a; req_b[2*W-1:W] = b;
        end
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 10 && resp_valid == 0; i++) step();
        chk("resp_wait", 64'(resp_valid != 0), 1);
    endtask

    initial begin
        req_valid = 2'b11;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_alu", {alu_ctrl, alu_a[15:0], alu_b[15:0]}, 0);
        repeat (3) step();
        set_op(0, 3'b000, 7'h00, 5, 7);
        set_op(1, 3'b000, 7'h20, 3, 5);
        resp_ready = 2'b11;
        rst_n = 1;
        repeat (12) step();
        req_valid = 2'b01;
        set_op(0, 3'b100, 7'h00, 9, 9);
        repeat (6) step();
        set_op(0, 3'b001, 7'h00, 32'h1, 32'd4);
        resp_ready = 2'b00;
        wait_resp();
        req_valid = 2'b00;
        resp_ready = 2'b10;
        repeat (5) step();
        resp_ready = 2'b01;
        step();
        resp_ready = 2'b00;
        req_valid = 2'b01;
        set_op(0, 3'b010, 7'h00, 32'hFFFF_FFF0, 32'd3);
        wait_resp();
        req_valid = 2'b00;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_req_ready", req_ready, 0);
        chk("abort_resp_err", resp_err, 0);
        q.delete();
        pref = 0;
        step();
        step();
        set_op(0, 3'b111, 7'h00, 32'hF0F0, 32'h0FF0);
        set_op(1, 3'b110, 7'h20, 32'h1234, 32'h8000);
        req_valid = 2'b11;
        resp_ready = 2'b11;
        rst_n = 1;
        repeat (12) step();
        repeat (3000) begin
            req_valid = 2'($urandom);
            req_funct3 = 6'($urandom);
            req_funct7 = 14'($urandom);
            req_a = {$urandom, $urandom};
            req_b = {$urandom, $urandom};
            resp_ready = 2'($urandom);
            step();
        end
        req_valid = 2'b00;
        resp_ready = 2'b11;
        repeat (10) step();
        chk("drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset is asynchronous and active-low.
REQ-004 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept strobe; at most one bit high.
REQ-006 req_funct3  input  6  requester i funct3 at [3i+2:3i].
REQ-007 req_funct7  input  14  requester i funct7 at [7i+6:7i]; only bit 5 of each field is decoded.
REQ-008 req_a, req_b  input  2*WIDTH each  requester i operand at [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-009 alu_a, alu_b  output  WIDTH each  operands to the shared combinational ALU.
REQ-010 alu_ctrl  output  3  operation code to the shared ALU.
REQ-011 alu_result  input  WIDTH  shared ALU result, combinational from alu_a/alu_b/alu_ctrl.
REQ-012 resp_valid  output  2  per-requester response valid; at most one bit high.
REQ-013 resp_ready  input  2  per-requester response accept.
REQ-014 resp_data  output  WIDTH  response result, shared by both requesters.
REQ-015 resp_err  output  1  response flags an illegal operation; qualified by resp_valid.

Function
REQ-016 FSM states: IDLE, ISSUE, RESP; single outstanding operation at a time.
REQ-017 IDLE: when any req_valid bit is set, grant one requester, assert its req_ready for exactly one cycle, latch its funct3/funct7[5]/a/b, move to ISSUE, or to RESP if the op is illegal.
REQ-018 req_ready is asserted only in IDLE and only for the granted requester; a request is accepted only when req_valid[i] and req_ready[i] are both high in the same cycle.
REQ-019 Arbitration: round-robin; priority pointer names the preferred requester; with both valid, the pointer's requester wins; with one valid, that requester wins regardless of pointer.
REQ-020 Pointer update: on response handshake, pointer becomes the requester not just served.
REQ-021 Decode of {funct7[5],funct3}: 0000 ADD->001, 1000 SUB->000, 0111 AND->010, 0110 OR->011, 0001 SLL->100, 0010 SLT->110; any other code is illegal.
REQ-022 ISSUE: drive latched operands and decoded alu_ctrl for exactly one cycle; capture alu_result into resp_data at the clock edge ending that cycle; move to RESP.
REQ-023 Outside ISSUE, alu_a, alu_b and alu_ctrl hold 0.
REQ-024 Illegal op: no ISSUE cycle; resp_data=0, resp_err=1.
REQ-025 RESP: hold resp_valid[granted], resp_data and resp_err stable until resp_ready[granted]; on handshake return to IDLE with resp_valid cleared the next cycle.
REQ-026 resp_ready on the non-granted bit is ignored.
REQ-027 Latency, legal op: accept at cycle T, ISSUE at T+1, resp_valid high at T+2; illegal op: resp_valid high at T+1.
REQ-028 Throughput: next acceptance is no earlier than the cycle after response handshake (IDLE re-entry).
REQ-029 Requester inputs may change freely after acceptance; only latched values are used.

Reset
REQ-030 rst_n low forces asynchronously: state IDLE, pointer=0, req_ready=0, resp_valid=0, resp_data=0, resp_err=0, alu_a=0, alu_b=0, alu_ctrl=0.
REQ-031 Reset mid-operation (ISSUE or RESP) aborts the operation with no response; after release the block re-arbitrates from IDLE.
REQ-032 The first acceptance occurs no earlier than the first rising edge with rst_n high.

Verification
REQ-033 Req0 only: funct3=000, funct7=0x00, a=5, b=7 -> alu_ctrl=001 at T+1; resp_valid=01, resp_data=12, resp_err=0 at T+2.
REQ-034 Req1 only: funct7=0x20, funct3=000, a=3, b=5 -> alu_ctrl=000; resp_data=0xFFFFFFFE (WIDTH=32).
REQ-035 Both valid after reset -> req0 served first, then req1 with no intervening req0 grant although req0 remains valid; the third grant goes back to req0.
REQ-036 Illegal op funct3=100, funct7=0x00 -> no ISSUE cycle, alu_ctrl stays 0; resp_valid at T+1, resp_err=1, resp_data=0.
REQ-037 resp_ready held low 5 cycles in RESP -> resp_valid/resp_data stable all 5 cycles, no new req_ready; handshake on cycle 6 -> IDLE the next cycle.
REQ-038 rst_n asserted during RESP -> resp_valid drops immediately without waiting for a clock edge; pointer=0; no response is delivered for the aborted operation.
